// File: rtl/button_pkg.sv
// Shared mode encodings for the button bank and its per-channel debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL     = 2'd0,
        MODE_TOG_REL   = 2'd1,
        MODE_TOG_PRESS = 2'd2,
        MODE_LEVEL_ALT = 2'd3
    } mode_e;

    localparam int unsigned MODE_W = 2;

endpackage

// File: rtl/button_bank_if.sv
// Signal bundle between the button bank and its host; master drives pins/config, slave is the bank.
interface button_bank_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0]   button;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   init_status;
    logic              status_load;
    logic [N_CH-1:0]   stable;
    logic [N_CH-1:0]   press_pulse;
    logic [N_CH-1:0]   release_pulse;
    logic [N_CH-1:0]   status;
    logic [N_CH-1:0]   long_pulse;

    modport master (
        output button, mode, init_status, status_load,
        input  stable, press_pulse, release_pulse, status, long_pulse
    );

    modport slave (
        input  button, mode, init_status, status_load,
        output stable, press_pulse, release_pulse, status, long_pulse
    );
endinterface

// File: rtl/button_channel.sv
// One debounced button channel: synchroniser, debounce counter, edge pulses, mode status.
// Optional long-press detection under BUTTON_LONGPRESS_EN.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 14,
    parameter int unsigned LONG_CYC     = 50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              button_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              init_status_i,
    input  logic              status_load_i,
    output logic              stable_o,
    output logic              press_pulse_o,
    output logic              release_pulse_o,
    output logic              status_o,
    output logic              long_pulse_o
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d, stable_dly_q;
    logic             press_q, press_d, release_q, release_d;
    logic             status_q, status_d;
    logic             suppress_tog;
    mode_e            mode_s;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync_q[1];
            else                   cnt_d    = cnt_q + 1'b1;
        end
        // Pulses trail the stable change by one cycle.
        press_d   = stable_q & ~stable_dly_q;
        release_d = ~stable_q & stable_dly_q;

        mode_s   = mode_e'(mode_i);
        status_d = status_q;
        unique case (mode_s)
            MODE_TOG_REL:   if (release_d && !suppress_tog) status_d = ~status_q;
            MODE_TOG_PRESS: if (press_d) status_d = ~status_q;
            default:        status_d = stable_d;
        endcase
        if (status_load_i) status_d = init_status_i;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            status_q     <= init_status_i;
        end else begin
            sync_q       <= {sync_q[0], button_i};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            release_q    <= release_d;
            status_q     <= status_d;
        end
    end

`ifdef BUTTON_LONGPRESS_EN
    localparam int unsigned       HOLD_W   = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d, long_done_q, long_done_d;

    always_comb begin
        hold_d = '0;
        if (stable_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
        // Remember the long press until its release pulse has been consumed.
        long_done_d = release_d ? 1'b0 : (long_done_q | long_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q      <= '0;
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_q      <= long_d;
            long_done_q <= long_done_d;
        end
    end

    assign suppress_tog = long_done_q;
    assign long_pulse_o = long_q;
`else
    assign suppress_tog = 1'b0;
    assign long_pulse_o = 1'b0;
`endif

    assign stable_o        = stable_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign status_o        = status_q;
endmodule

// File: rtl/button_bank.sv
// Bank of N_CH independent debounced buttons with per-channel mode status.
// Long-press detection is compiled in with BUTTON_LONGPRESS_EN.
module button_bank
    import button_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DEBOUNCE_CYC = 14,
    parameter int unsigned LONG_CYC     = 50000000
) (
    input  logic         clk,
    input  logic         reset_n,
    button_bank_if.slave bus
);
    logic [N_CH-1:0] stable_v, press_v, release_v, status_v, long_v;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .clk             (clk),
            .reset_n         (reset_n),
            .button_i        (bus.button[i]),
            .mode_i          (bus.mode[MODE_W*i +: MODE_W]),
            .init_status_i   (bus.init_status[i]),
            .status_load_i   (bus.status_load),
            .stable_o        (stable_v[i]),
            .press_pulse_o   (press_v[i]),
            .release_pulse_o (release_v[i]),
            .status_o        (status_v[i]),
            .long_pulse_o    (long_v[i])
        );
    end

    assign bus.stable        = stable_v;
    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.status        = status_v;
    assign bus.long_pulse    = long_v;
endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank (N_CH=4, DEBOUNCE_CYC=16, LONG_CYC=100); long-press
// expectations follow BUTTON_LONGPRESS_EN.
module tb_button_bank;
    logic clk;
    logic reset_n;
    int   passes;
    int   fails;
    int   checks;

    button_bank_if #(.N_CH(4)) bus ();

    button_bank #(
        .N_CH         (4),
        .DEBOUNCE_CYC (16),
        .LONG_CYC     (100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    localparam logic [7:0] MODES = 8'b10_01_00_00;

    initial begin
        logic [3:0] seen_p, seen_r, seen_s;
        int         long_cnt, rel_cnt;
        passes = 0; fails = 0; checks = 0;

        reset_n = 1'b0;
        bus.button = '0;
        bus.mode = MODES;
        bus.init_status = '0;
        bus.status_load = 1'b0;
        step(2);
        chk("rst_stable",  32'(bus.stable),        32'h0);
        chk("rst_press",   32'(bus.press_pulse),   32'h0);
        chk("rst_release", 32'(bus.release_pulse), 32'h0);
        chk("rst_status",  32'(bus.status),        32'h0);
        chk("rst_long",    32'(bus.long_pulse),    32'h0);
        reset_n = 1'b1;
        step(2);

        // 10-cycle glitch on ch0 must be rejected
        seen_p = '0; seen_s = '0;
        bus.button = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) bus.button = 4'b0000;
            step(1);
            seen_p |= bus.press_pulse;
            seen_s |= bus.stable;
        end
        chk("glitch_stable", 32'(seen_s),     32'h0);
        chk("glitch_press",  32'(seen_p),     32'h0);
        chk("glitch_status", 32'(bus.status), 32'h0);

        // clean press on ch1, level mode: pulse 19 cycles after pin edge
        bus.button = 4'b0010;
        step(18);
        chk("press_early",   32'(bus.press_pulse), 32'h0);
        chk("stable_ch1",    32'(bus.stable),      32'h2);
        chk("status_lvl",    32'(bus.status),      32'h2);
        step(1);
        chk("press_at19",    32'(bus.press_pulse), 32'h2);
        step(1);
        chk("press_oneshot", 32'(bus.press_pulse), 32'h0);
        step(20);
        chk("status_held",   32'(bus.status),      32'h2);
        bus.button = 4'b0000;
        step(19);
        chk("release_at19",  32'(bus.release_pulse), 32'h2);
        step(1);
        chk("release_one",   32'(bus.release_pulse), 32'h0);
        chk("status_lvl0",   32'(bus.status),        32'h0);

        // ch2 toggle-on-release, two press/release cycles
        bus.button = 4'b0100; step(30);
        chk("tog_rel_press1", 32'(bus.status), 32'h0);
        bus.button = 4'b0000; step(30);
        chk("tog_rel_rel1",   32'(bus.status), 32'h4);
        bus.button = 4'b0100; step(30);
        bus.button = 4'b0000; step(30);
        chk("tog_rel_rel2",   32'(bus.status), 32'h0);

        // simultaneous press on ch0 (level) and ch3 (toggle-on-press)
        bus.button = 4'b1001;
        step(19);
        chk("simul_press",  32'(bus.press_pulse), 32'h9);
        chk("simul_status", 32'(bus.status),      32'h9);
        bus.button = 4'b0000;
        step(30);
        chk("tog_press_rel", 32'(bus.status), 32'h8);

        // status_load alone, then coinciding with a mode-1 release toggle
        bus.init_status = 4'b0100;
        bus.status_load = 1'b1; step(1); bus.status_load = 1'b0;
        chk("load_only",  32'(bus.status), 32'h4);
        step(1);
        chk("load_after", 32'(bus.status), 32'h4);
        bus.button = 4'b0100; step(30);
        bus.button = 4'b0000; step(18);
        bus.status_load = 1'b1; step(1); bus.status_load = 1'b0;
        chk("load_tog_rel",    32'(bus.release_pulse), 32'h4);
        chk("load_tog_status", 32'(bus.status),        32'h4);
        step(1);
        chk("load_tog_hold",   32'(bus.status),        32'h4);

        // mode change leaves a toggle-mode status untouched
        bus.mode = 8'b10_10_00_00; step(2);
        chk("mode_change", 32'(bus.status), 32'h4);
        bus.mode = MODES; step(1);

        // 150-cycle hold on ch2 in mode 1
        long_cnt = 0; rel_cnt = 0;
        bus.button = 4'b0100;
        for (int k = 0; k < 150; k++) begin
            step(1);
            long_cnt += int'(bus.long_pulse[2]);
        end
        bus.button = 4'b0000;
        for (int k = 0; k < 30; k++) begin
            step(1);
            long_cnt += int'(bus.long_pulse[2]);
            rel_cnt  += int'(bus.release_pulse[2]);
        end
        chk("hold_rel_cnt", 32'(rel_cnt), 32'd1);
`ifdef BUTTON_LONGPRESS_EN
        chk("long_cnt",    32'(long_cnt),   32'd1);
        chk("long_no_tog", 32'(bus.status), 32'h4);
`else
        chk("long_cnt",    32'(long_cnt),   32'd0);
        chk("long_tog",    32'(bus.status), 32'h0);
`endif

        // reset in the middle of a debounce
        bus.init_status = 4'b1010;
        bus.button = 4'b0011;
        step(10);
        reset_n = 1'b0;
        step(1);
        chk("mid_rst_press",   32'(bus.press_pulse),   32'h0);
        chk("mid_rst_release", 32'(bus.release_pulse), 32'h0);
        chk("mid_rst_stable",  32'(bus.stable),        32'h0);
        chk("mid_rst_status",  32'(bus.status),        32'ha);
        chk("mid_rst_long",    32'(bus.long_pulse),    32'h0);
        reset_n = 1'b1;
        bus.button = 4'b0000;
        seen_p = '0; seen_r = '0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            seen_p |= bus.press_pulse;
            seen_r |= bus.release_pulse;
        end
        chk("post_rst_press",   32'(seen_p),     32'h0);
        chk("post_rst_release", 32'(seen_r),     32'h0);
        chk("post_rst_status",  32'(bus.status), 32'h8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
